mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit with an architectural HI/LO register pair, for the EX stage of the MIPS core. It runs mult, multu, div and divu as a fixed-latency multi-cycle operation with a start/busy/done handshake, and supports exception flush. EX raises start and stalls the pipeline while busy is high. It also serves mthi/mtlo writes and mfhi/mflo reads.

---
 rtl/mdu_iter_pkg.sv | 32 +++
 rtl/mdu_hilo_reg.sv | 35 +++
 rtl/mdu_iter.sv | 171 +++++++++++++++++
 tb/tb_mdu_iter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_iter_pkg;

    // Operation encodings carried on the op input.
    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    // Existing single-bit flag constants used across the core.
    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;
    localparam logic ZERO    = 1'b0;

    // Sequencer states; exported on state_dbg.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // mult and div are the signed flavours (op[0] clear).
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    // div and divu share the op[1] bit.
    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_hilo_reg.sv
// Architectural HI/LO storage. A finished operation writes both halves;
// mthi/mtlo writes land only while the unit is not busy.
module mdu_hilo_reg
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             busy,
    input  logic             whi,
    input  logic             wlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             res_we,
    input  logic [WIDTH-1:0] res_hi,
    input  logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Result write has priority; move-to writes are dropped while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (res_we == VALID) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (!busy) begin
            if (whi) hi <= wdata;
            if (wlo) lo <= wdata;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit for the EX stage.
// Handshake: start is taken only in IDLE when cancel is low; busy stays high
// through CALC and FIX; done pulses for one cycle once HI/LO hold the result,
// WIDTH+1 cycles after acceptance. cancel in CALC/FIX drops the operation.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             whi,
    input  logic             wlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_e state_q, state_d;
    logic accept, step, commit;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             is_div_q, neg_res_q, neg_rem_q, dz_q;
    logic             done_q, dbz_q;

    // Operand preparation: magnitudes and sign flags for signed ops.
    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign sgn   = is_signed_op(op);
    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Single-step arithmetic: shift-add multiply, restoring divide.
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    // Final sign correction; a zero divisor keeps an all-ones quotient and
    // the remainder magnitude re-signed by a, which restores a exactly.
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;
    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_res_q ? -prod : prod;
    assign quo_fix  = dz_q ? '1 : (neg_res_q ? -acc_lo : acc_lo);
    assign rem_fix  = neg_rem_q ? -acc_hi : acc_hi;
    assign res_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d = state_q;
        accept  = INVALID;
        step    = INVALID;
        commit  = INVALID;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    accept  = VALID;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    step = VALID;
                    if (cnt == LAST) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!cancel) commit = VALID;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch operands at acceptance, then one radix-2 step per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            is_div_q  <= ZERO;
            neg_res_q <= ZERO;
            neg_rem_q <= ZERO;
            dz_q      <= ZERO;
        end else if (accept) begin
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= a_mag;
            opnd      <= b_mag;
            is_div_q  <= is_div_op(op);
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dz_q      <= is_div_op(op) && (b == '0);
        end else if (step) begin
            cnt <= cnt + CW'(1);
            if (is_div_q) begin
                if (div_ge) begin
                    acc_hi <= div_diff;
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    // Completion status: done pulse and per-operation divide-by-zero flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= ZERO;
            dbz_q  <= ZERO;
        end else begin
            done_q <= commit;
            if (accept)      dbz_q <= ZERO;
            else if (commit) dbz_q <= dz_q;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign state_dbg   = state_q;

    mdu_hilo_reg #(.WIDTH(WIDTH)) u_hilo (
        .clk    (clk),
        .rst    (rst),
        .busy   (busy),
        .whi    (whi),
        .wlo    (wlo),
        .wdata  (wdata),
        .res_we (commit),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .hi     (hi),
        .lo     (lo)
    );

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: arithmetic vectors, latency, cancel,
// move-to writes and asynchronous reset.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, cancel, whi, wlo;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    mdu_iter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .cancel      (cancel),
        .whi         (whi),
        .wlo         (wlo),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .state_dbg   (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle; returns just after the accepting edge.
    task automatic start_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
        op    = o;
        a     = aa;
        b     = bb;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count edges until done shows, bounded.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        check("busy_at_done", {63'd0, busy}, 64'd0);
    endtask

    task automatic push_exp(input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
        exp_q.push_back(eh);
        exp_q.push_back(el);
        exp_q.push_back({{(W-1){1'b0}}, edz});
    endtask

    // Compare HI/LO/div_by_zero in the done cycle, then confirm done drops.
    task automatic compare_result(input string tag);
        logic [W-1:0] eh, el, ed;
        eh = exp_q.pop_front();
        el = exp_q.pop_front();
        ed = exp_q.pop_front();
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
        check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, ed[0]});
        tick();
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    logic [1:0]   t_op [10];
    logic [W-1:0] t_a  [10];
    logic [W-1:0] t_b  [10];
    logic [W-1:0] t_hi [10];
    logic [W-1:0] t_lo [10];
    logic         t_dz [10];

    initial begin
        int lat, bc, pulses;

        t_op[0] = 2'b00; t_a[0] = 32'hFFFFFFFE; t_b[0] = 32'h3;        t_hi[0] = 32'hFFFFFFFF; t_lo[0] = 32'hFFFFFFFA; t_dz[0] = 0;
        t_op[1] = 2'b01; t_a[1] = 32'hFFFFFFFF; t_b[1] = 32'hFFFFFFFF; t_hi[1] = 32'hFFFFFFFE; t_lo[1] = 32'h00000001; t_dz[1] = 0;
        t_op[2] = 2'b10; t_a[2] = 32'hFFFFFFF9; t_b[2] = 32'h2;        t_hi[2] = 32'hFFFFFFFF; t_lo[2] = 32'hFFFFFFFD; t_dz[2] = 0;
        t_op[3] = 2'b10; t_a[3] = 32'h80000000; t_b[3] = 32'hFFFFFFFF; t_hi[3] = 32'h0;        t_lo[3] = 32'h80000000; t_dz[3] = 0;
        t_op[4] = 2'b11; t_a[4] = 32'h5;        t_b[4] = 32'h0;        t_hi[4] = 32'h5;        t_lo[4] = 32'hFFFFFFFF; t_dz[4] = 1;
        t_op[5] = 2'b11; t_a[5] = 32'd10;       t_b[5] = 32'd3;        t_hi[5] = 32'h1;        t_lo[5] = 32'h3;        t_dz[5] = 0;
        t_op[6] = 2'b10; t_a[6] = 32'd7;        t_b[6] = 32'hFFFFFFFE; t_hi[6] = 32'h1;        t_lo[6] = 32'hFFFFFFFD; t_dz[6] = 0;
        t_op[7] = 2'b10; t_a[7] = 32'hFFFFFFF9; t_b[7] = 32'h0;        t_hi[7] = 32'hFFFFFFF9; t_lo[7] = 32'hFFFFFFFF; t_dz[7] = 1;
        t_op[8] = 2'b00; t_a[8] = 32'h80000000; t_b[8] = 32'h80000000; t_hi[8] = 32'h40000000; t_lo[8] = 32'h0;        t_dz[8] = 0;
        t_op[9] = 2'b01; t_a[9] = 32'h0;        t_b[9] = 32'h12345678; t_hi[9] = 32'h0;        t_lo[9] = 32'h0;        t_dz[9] = 0;

        // Reset.
        rst = 1'b0; start = 1'b0; cancel = 1'b0; whi = 1'b0; wlo = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (3) tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_state", {62'd0, state_dbg}, 64'd0);
        rst = 1'b1;
        tick();

        // Arithmetic vectors, each with latency and busy-length checks.
        for (int i = 0; i < 10; i++) begin
            push_exp(t_hi[i], t_lo[i], t_dz[i]);
            start_op(t_op[i], t_a[i], t_b[i]);
            wait_done(lat, bc);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("v%0d_busy_len", i), 64'(bc), 64'd33);
            compare_result($sformatf("v%0d", i));
        end

        // Preload through mthi/mtlo.
        whi = 1'b1; wdata = 32'h1234;
        tick();
        whi = 1'b0; wlo = 1'b1; wdata = 32'h5678;
        tick();
        wlo = 1'b0;
        check("pre_hi", {32'd0, hi}, 64'h1234);
        check("pre_lo", {32'd0, lo}, 64'h5678);

        // Cancel mid-CALC: no write, no done, restart the next cycle.
        start_op(2'b00, 32'd3, 32'd4);
        repeat (10) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", {63'd0, busy}, 64'd0);
        check("cancel_done", {63'd0, done}, 64'd0);
        check("cancel_hi", {32'd0, hi}, 64'h1234);
        check("cancel_lo", {32'd0, lo}, 64'h5678);
        push_exp(32'h0, 32'd12, 1'b0);
        start_op(2'b00, 32'd3, 32'd4);
        check("restart_busy", {63'd0, busy}, 64'd1);
        wait_done(lat, bc);
        check("restart_latency", 64'(lat), 64'd33);
        compare_result("restart");

        // Cancel in FIX beats the result write.
        start_op(2'b01, 32'd5, 32'd6);
        repeat (32) tick();
        check("fix_state", {62'd0, state_dbg}, 64'd2);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("fixcancel_done", {63'd0, done}, 64'd0);
        check("fixcancel_busy", {63'd0, busy}, 64'd0);
        check("fixcancel_hi", {32'd0, hi}, 64'h0);
        check("fixcancel_lo", {32'd0, lo}, 64'd12);

        // mthi together with an accepted start: written at acceptance, then overwritten.
        whi = 1'b1; wdata = 32'hAAAA;
        push_exp(32'h1, 32'h3, 1'b0);
        start_op(2'b11, 32'd10, 32'd3);
        whi = 1'b0;
        check("wstart_hi", {32'd0, hi}, 64'hAAAA);
        check("wstart_busy", {63'd0, busy}, 64'd1);
        wait_done(lat, bc);
        compare_result("wstart");

        // Start and mthi while busy are both ignored.
        push_exp(32'h0, 32'h20, 1'b0);
        start_op(2'b00, 32'd4, 32'd8);
        repeat (4) tick();
        start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        whi = 1'b1; wdata = 32'hDEAD;
        tick();
        start = 1'b0; whi = 1'b0;
        check("busy_whi_hi", {32'd0, hi}, 64'h1);
        check("busy_whi_lo", {32'd0, lo}, 64'h3);
        wait_done(lat, bc);
        check("busy_start_latency", 64'(lat), 64'd28);
        compare_result("busy_start");
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            tick();
        end
        check("busy_start_extra_done", 64'(pulses), 64'd0);

        // Asynchronous reset in the middle of a divide.
        start_op(2'b10, 32'd100, 32'd7);
        repeat (19) tick();
        rst = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_hi", {32'd0, hi}, 64'd0);
        check("arst_lo", {32'd0, lo}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        check("arst_state", {62'd0, state_dbg}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
